// File: rtl/control_multiciclo_pkg.sv
// control_multiciclo_pkg: opcodes, alu_op codes, state encodings and control bundle for the multi-cycle MIPS control.
package control_multiciclo_pkg;
  localparam int OPW = 6;
  localparam int AOPW = 3;
  localparam logic [OPW-1:0] OPC_R    = 6'b000000;
  localparam logic [OPW-1:0] OPC_LW   = 6'b100011;
  localparam logic [OPW-1:0] OPC_SW   = 6'b101011;
  localparam logic [OPW-1:0] OPC_BEQ  = 6'b000100;
  localparam logic [OPW-1:0] OPC_J    = 6'b000010;
  localparam logic [OPW-1:0] OPC_ADDI = 6'b001000;
  localparam logic [OPW-1:0] OPC_ORI  = 6'b001101;
  localparam logic [OPW-1:0] OPC_ANDI = 6'b001100;
  localparam logic [OPW-1:0] OPC_SLTI = 6'b001010;
  localparam logic [AOPW-1:0] ALU_ADD   = 3'b000;
  localparam logic [AOPW-1:0] ALU_SUB   = 3'b001;
  localparam logic [AOPW-1:0] ALU_RTYPE = 3'b010;
  localparam logic [AOPW-1:0] ALU_ADDI  = 3'b011;
  localparam logic [AOPW-1:0] ALU_ORI   = 3'b100;
  localparam logic [AOPW-1:0] ALU_ANDI  = 3'b101;
  localparam logic [AOPW-1:0] ALU_SLTI  = 3'b110;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RWB, S_BRANCH, S_JUMP, S_IEXEC, S_IWB
  } state_t;
  typedef struct packed {
    logic pc_write;
    logic pc_write_cond;
    logic i_or_d;
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic mem_to_reg;
    logic reg_dst;
    logic reg_write;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic imm_zext;
    logic [1:0] pc_source;
    logic [AOPW-1:0] alu_op;
  } ctrl_t;
  // S_FETCH doubles as the "unknown opcode" verdict
  function automatic state_t dispatch(input logic [OPW-1:0] op);
    case (op)
      OPC_LW, OPC_SW: return S_MEMADR;
      OPC_R: return S_EXEC;
      OPC_BEQ: return S_BRANCH;
      OPC_J: return S_JUMP;
      OPC_ADDI, OPC_ORI, OPC_ANDI, OPC_SLTI: return S_IEXEC;
      default: return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/control_multiciclo_if.sv
// control_multiciclo_if: control unit <-> datapath bundle (opcode/mem_ready in, mux selects and enables out).
interface control_multiciclo_if;
  import control_multiciclo_pkg::*;
  logic [OPW-1:0] opcode;
  logic mem_ready;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, imm_zext, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [AOPW-1:0] alu_op;
  logic [3:0] state;
  modport master (
    input opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, imm_zext,
      pc_source, alu_op, illegal, state
  );
  modport slave (
    output opcode, mem_ready,
    input pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, imm_zext,
      pc_source, alu_op, illegal, state
  );
endinterface

// File: rtl/control_salidas.sv
// control_salidas: Moore decoder from (state, op_q) to datapath controls; fetch writes also wait on mem_ready.
module control_salidas
  import control_multiciclo_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] op_q,
  input  logic           mem_ready,
  output ctrl_t          ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op = ALU_ADD;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op = ALU_RTYPE;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op = op_q == OPC_ORI ? ALU_ORI : op_q == OPC_ANDI ? ALU_ANDI : op_q == OPC_SLTI ? ALU_SLTI : ALU_ADDI;
        ctrl.imm_zext = op_q == OPC_ORI || op_q == OPC_ANDI;
      end
      S_IWB: ctrl.reg_write = 1'b1;
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo: multi-cycle MIPS main control FSM with memory wait states.
// Outputs are forced to zero while rst is high so no enable fires during reset.
module control_multiciclo
  import control_multiciclo_pkg::*;
(
  input logic clk,
  input logic rst,
  control_multiciclo_if.master bus
);
  state_t state_q, state_d;
  logic [OPW-1:0] op_q;
  logic illegal_q, illegal_d;
  ctrl_t dec, ctrl;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
    end
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dispatch(bus.opcode);
      S_MEMADR: state_d = op_q == OPC_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD: state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC: state_d = S_RWB;
      S_IEXEC: state_d = S_IWB;
      default: state_d = S_FETCH;
    endcase
  end
  // flagged on leaving DECODE, seen during the following FETCH cycle only
  assign illegal_d = state_q == S_DECODE && dispatch(bus.opcode) == S_FETCH;
  control_salidas u_salidas (.state(state_q), .op_q(op_q), .mem_ready(bus.mem_ready), .ctrl(dec));
  assign ctrl = rst ? '0 : dec;
  assign bus.pc_write = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d = ctrl.i_or_d;
  assign bus.mem_read = ctrl.mem_read;
  assign bus.mem_write = ctrl.mem_write;
  assign bus.ir_write = ctrl.ir_write;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_dst = ctrl.reg_dst;
  assign bus.reg_write = ctrl.reg_write;
  assign bus.alu_src_a = ctrl.alu_src_a;
  assign bus.alu_src_b = ctrl.alu_src_b;
  assign bus.imm_zext = ctrl.imm_zext;
  assign bus.pc_source = ctrl.pc_source;
  assign bus.alu_op = ctrl.alu_op;
  assign bus.illegal = illegal_q && !rst;
  assign bus.state = state_q;
endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: per-cycle scoreboard of state and control outputs over directed instruction sequences.
module tb_control_multiciclo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [22:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  control_multiciclo_if b();
  control_multiciclo dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  // en = {illegal,pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a}
  function automatic logic [22:0] v(input logic [3:0] st, input logic [10:0] en, input logic [1:0] asb,
                                    input logic iz, input logic [1:0] ps, input logic [2:0] aop);
    return {st, en, asb, iz, ps, aop};
  endfunction
  logic [22:0] RST, F1, F0, FI, DEC, MADR, MRD, MWB, MWR, EXE, RWB, BR, JMP, IEX_ORI, IWB;
  initial begin
    RST     = v(4'd0,  11'b00000000000, 2'b00, 1'b0, 2'b00, 3'b000);
    F1      = v(4'd0,  11'b01001010000, 2'b01, 1'b0, 2'b00, 3'b000);
    F0      = v(4'd0,  11'b00001000000, 2'b01, 1'b0, 2'b00, 3'b000);
    FI      = v(4'd0,  11'b11001010000, 2'b01, 1'b0, 2'b00, 3'b000);
    DEC     = v(4'd1,  11'b00000000000, 2'b11, 1'b0, 2'b00, 3'b000);
    MADR    = v(4'd2,  11'b00000000001, 2'b10, 1'b0, 2'b00, 3'b000);
    MRD     = v(4'd3,  11'b00011000000, 2'b00, 1'b0, 2'b00, 3'b000);
    MWB     = v(4'd4,  11'b00000001010, 2'b00, 1'b0, 2'b00, 3'b000);
    MWR     = v(4'd5,  11'b00010100000, 2'b00, 1'b0, 2'b00, 3'b000);
    EXE     = v(4'd6,  11'b00000000001, 2'b00, 1'b0, 2'b00, 3'b010);
    RWB     = v(4'd7,  11'b00000000110, 2'b00, 1'b0, 2'b00, 3'b000);
    BR      = v(4'd8,  11'b00100000001, 2'b00, 1'b0, 2'b01, 3'b001);
    JMP     = v(4'd9,  11'b01000000000, 2'b00, 1'b0, 2'b10, 3'b000);
    IEX_ORI = v(4'd10, 11'b00000000001, 2'b10, 1'b1, 2'b00, 3'b100);
    IWB     = v(4'd11, 11'b00000000010, 2'b00, 1'b0, 2'b00, 3'b000);
  end
  task automatic cyc(input logic r, input logic [5:0] op, input logic mr, input logic [22:0] e);
    @(posedge clk);
    #2;
    rst = r;
    b.opcode = op;
    b.mem_ready = mr;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] e, o;
      e = exp_q.pop_front();
      o = {b.state, b.illegal, b.pc_write, b.pc_write_cond, b.i_or_d, b.mem_read, b.mem_write,
           b.ir_write, b.mem_to_reg, b.reg_dst, b.reg_write, b.alu_src_a, b.alu_src_b,
           b.imm_zext, b.pc_source, b.alu_op};
      checks++;
      if (o !== e) $display("FAIL cycle %0d at %0t: got %b want %b", checks, $time, o, e);
      else passed++;
    end
  end
  initial begin
    b.opcode = 6'b0;
    b.mem_ready = 1'b0;
    cyc(1, 6'b000000, 0, RST);
    // lw: 5 cycles; opcode changes after DECODE must be ignored
    cyc(0, 6'b100011, 1, F1);
    cyc(0, 6'b100011, 1, DEC);
    cyc(0, 6'b000000, 1, MADR);
    cyc(0, 6'b000000, 1, MRD);
    cyc(0, 6'b000000, 1, MWB);
    // R-type
    cyc(0, 6'b000000, 1, F1);
    cyc(0, 6'b000000, 1, DEC);
    cyc(0, 6'b001101, 1, EXE);
    cyc(0, 6'b001101, 1, RWB);
    // ori
    cyc(0, 6'b001101, 1, F1);
    cyc(0, 6'b001101, 1, DEC);
    cyc(0, 6'b000000, 1, IEX_ORI);
    cyc(0, 6'b000000, 1, IWB);
    // sw with three wait cycles in MEMWR
    cyc(0, 6'b101011, 1, F1);
    cyc(0, 6'b101011, 1, DEC);
    cyc(0, 6'b000000, 0, MADR);
    cyc(0, 6'b000000, 0, MWR);
    cyc(0, 6'b000000, 0, MWR);
    cyc(0, 6'b000000, 0, MWR);
    cyc(0, 6'b000000, 1, MWR);
    // beq with one fetch wait state
    cyc(0, 6'b000100, 0, F0);
    cyc(0, 6'b000100, 1, F1);
    cyc(0, 6'b000100, 1, DEC);
    cyc(0, 6'b000000, 1, BR);
    // j
    cyc(0, 6'b000010, 1, F1);
    cyc(0, 6'b000010, 1, DEC);
    cyc(0, 6'b000000, 1, JMP);
    // illegal opcode: single pulse in the next FETCH
    cyc(0, 6'b111111, 1, F1);
    cyc(0, 6'b111111, 1, DEC);
    cyc(0, 6'b100011, 1, FI);
    // lw stalled in MEMRD, then asynchronous reset mid-cycle
    cyc(0, 6'b100011, 1, DEC);
    cyc(0, 6'b000000, 1, MADR);
    cyc(0, 6'b000000, 0, MRD);
    cyc(0, 6'b000000, 0, MRD);
    cyc(1, 6'b000000, 0, RST);
    cyc(0, 6'b000000, 1, F1);
    cyc(0, 6'b000000, 1, DEC);
    cyc(0, 6'b000000, 1, EXE);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
